die_face_reader: RTL and testbench
==================================

Name: die_face_reader

Overview:
- Receive-side companion to the one-hot die counter, which drives digits 1–6 onto a 7-segment bus.
- Samples an asynchronous 7-segment pattern, synchronizes it and filters it for stability.
- Decodes it back to a face value 1–6 and reports each settled roll with a one-cycle strobe.
- Keeps a roll counter and a sticky illegal-pattern flag; sits between the segment pins and downstream game or statistics logic.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a pattern counts as settled (≥1).
- CNT_W, 16, roll counter width.
- HIST_W, 8, per-face histogram counter width (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- seg_in  in  7  segment pattern, bit0=a … bit6=g, asynchronous to clk.
- clear  in  1  synchronous clear of roll_count, error and histogram.
- face  out  3  last settled face, 1..6; 0 before the first valid settle.
- face_valid  out  1  displayed pattern is settled and legal.
- face_strobe  out  1  one-cycle pulse per settle event.
- error  out  1  sticky: an illegal pattern settled.
- roll_count  out  CNT_W  number of strobes, wraps.
- hist_sel  in  3  face select 1..6 for histogram readout (feature only).
- hist_count  out  HIST_W  hits for hist_sel (feature only).

Behaviour:
- Reset: asynchronous on rst_n=0. Synchronizer flops, prev sample p, run counter, face, face_valid, face_strobe, error, roll_count and histogram all clear to 0.
- Synchronizer: 2-flop, reset value 0. The second stage output is s.
- Decode of s (combinational):
  - 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6.
  - 0x00 = BLANK.
  - Any other pattern = ILLEGAL.
- Stability tracking, each cycle:
  - If s≠p: p←s, run←0, face_valid←0.
  - Else if run<STABLE_CYCLES: run←run+1. run saturates at STABLE_CYCLES.
- Settle event: the cycle in which run steps from STABLE_CYCLES−1 to STABLE_CYCLES. Action depends on the decode of p:
  - Legal face: face←decode, face_valid←1, face_strobe←1 for one cycle, roll_count←roll_count+1 (wraps).
  - BLANK: no strobe, no error, face_valid stays 0, face holds its value.
  - ILLEGAL: error←1 (sticky), face_valid stays 0, no strobe.
- Latency: face_strobe is high in the cycle following the (STABLE_CYCLES+3)th rising edge after seg_in changes (2 synchronizer + 1 capture + STABLE_CYCLES).
- A repeated identical face after an intervening change or BLANK produces a new strobe. A static display never re-strobes.
- A pattern change shorter than STABLE_CYCLES+1 samples produces no event; glitches are absorbed.
- clear with a simultaneous settle event: clear wins for error and histogram. roll_count loads 1 if the event is a legal face, otherwise 0.
- clear does not affect face, face_valid or face_strobe.
- rst_n asserted mid-settle: all state is lost immediately. After release, a full STABLE_CYCLES+3 edges are required before any event.
- FSM, encoded implicitly by run/p:
  - TRACKING: run<STABLE_CYCLES.
  - SETTLED: run==STABLE_CYCLES.
  - SETTLED→TRACKING on any change of s.

Optional Feature:
- Macro: DIE_FACE_READER_HIST_EN.
- Defined:
  - Six HIST_W counters, one per face, increment on each legal settle event and saturate at all-ones.
  - Cleared by rst_n and clear.
  - hist_count = counter[hist_sel]; 0 for hist_sel of 0 or 7.
- Undefined: no counters are built, hist_count is tied to 0 and hist_sel is ignored.

Decomposition:
- Package die_pkg:
  - face_t (3-bit) typedef.
  - SEG_FACE1..SEG_FACE6 and SEG_BLANK constants.
  - Decode-class enum {LEGAL, BLANK, ILLEGAL}.
- One sub-module, die_seg_decode: combinational, seg[6:0] → face_t plus class; shared with future display checkers.

Test Plan (STABLE_CYCLES=4):
- Hold 0x4F from reset release → face_strobe pulses once, 7 edges after the first sampled change; face=3, face_valid=1, roll_count=1. With HIST_EN, hist_sel=3 gives hist_count=1.
- 0x66 for 3 cycles then 0x7D held → no event for 4; exactly one strobe with face=6; roll_count increments by 1.
- Hold 0x7F → error=1, face_valid=0, no strobe. Then pulse clear → error=0, roll_count=0, face unchanged.
- Cycle 1..6 patterns at 2 cycles each, then hold 0x6D → exactly one strobe, face=5.
- 0x06 settled, 0x00 for 6 cycles, 0x06 again → two strobes, roll_count=2, error=0, face_valid=0 during blank.
- Assert rst_n for 1 cycle at run=3 while holding 0x5B → all outputs 0 immediately; strobe 7 edges after release with face=2, roll_count=1.

Source files
------------

// File: rtl/die_pkg.sv
// Shared types and segment encodings for the die face reader and its display-side checkers.
package die_pkg;

    typedef logic [2:0] face_t;

    // Segment order is bit0=a ... bit6=g.
    localparam logic [6:0] SEG_FACE1 = 7'h06;
    localparam logic [6:0] SEG_FACE2 = 7'h5B;
    localparam logic [6:0] SEG_FACE3 = 7'h4F;
    localparam logic [6:0] SEG_FACE4 = 7'h66;
    localparam logic [6:0] SEG_FACE5 = 7'h6D;
    localparam logic [6:0] SEG_FACE6 = 7'h7D;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        LEGAL,
        BLANK,
        ILLEGAL
    } seg_class_t;

endpackage

// File: rtl/die_seg_decode.sv
// Combinational 7-segment to die face decoder; anything not a face or blank is illegal.
module die_seg_decode
    import die_pkg::*;
(
    input  logic [6:0] seg,
    output face_t      face,
    output seg_class_t seg_class
);

    always_comb begin
        face      = '0;
        seg_class = ILLEGAL;
        case (seg)
            SEG_FACE1: begin face = 3'd1; seg_class = LEGAL; end
            SEG_FACE2: begin face = 3'd2; seg_class = LEGAL; end
            SEG_FACE3: begin face = 3'd3; seg_class = LEGAL; end
            SEG_FACE4: begin face = 3'd4; seg_class = LEGAL; end
            SEG_FACE5: begin face = 3'd5; seg_class = LEGAL; end
            SEG_FACE6: begin face = 3'd6; seg_class = LEGAL; end
            SEG_BLANK: seg_class = BLANK;
            default:   seg_class = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/die_face_reader.sv
// Synchronizes, debounces and decodes an asynchronous 7-segment die display.
// Optional per-face histogram is built when DIE_FACE_READER_HIST_EN is defined.
module die_face_reader
    import die_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned HIST_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic              clear,
    output face_t             face,
    output logic              face_valid,
    output logic              face_strobe,
    output logic              error,
    output logic [CNT_W-1:0]  roll_count,
    input  logic [2:0]        hist_sel,
    output logic [HIST_W-1:0] hist_count
);

    localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

    logic [6:0]       sync_q, s_q, p_q, p_d;
    logic [RUN_W-1:0] run_q, run_d;
    face_t            face_q, face_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] roll_q, roll_d;

    face_t      p_face;
    seg_class_t p_class;
    logic       settle, legal_settle, illegal_settle;

    die_seg_decode u_decode (
        .seg       (p_q),
        .face      (p_face),
        .seg_class (p_class)
    );

    // Settle fires once, on the step into saturation; a static display never re-fires.
    assign settle         = (s_q == p_q) && (run_q == RUN_LAST);
    assign legal_settle   = settle && (p_class == LEGAL);
    assign illegal_settle = settle && (p_class == ILLEGAL);

    always_comb begin
        p_d      = p_q;
        run_d    = run_q;
        face_d   = face_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        error_d  = error_q;
        roll_d   = roll_q;

        if (s_q != p_q) begin
            p_d     = s_q;
            run_d   = '0;
            valid_d = 1'b0;
        end else if (run_q < RUN_MAX) begin
            run_d = run_q + 1'b1;
        end

        if (legal_settle) begin
            face_d   = p_face;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
            roll_d   = roll_q + 1'b1;
        end
        if (illegal_settle) begin
            error_d = 1'b1;
        end

        // A coincident legal settle still counts as the first roll after clear.
        if (clear) begin
            error_d = 1'b0;
            roll_d  = legal_settle ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_q      <= '0;
            p_q      <= '0;
            run_q    <= '0;
            face_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
            roll_q   <= '0;
        end else begin
            sync_q   <= seg_in;
            s_q      <= sync_q;
            p_q      <= p_d;
            run_q    <= run_d;
            face_q   <= face_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            error_q  <= error_d;
            roll_q   <= roll_d;
        end
    end

    assign face        = face_q;
    assign face_valid  = valid_q;
    assign face_strobe = strobe_q;
    assign error       = error_q;
    assign roll_count  = roll_q;

`ifdef DIE_FACE_READER_HIST_EN
    logic [HIST_W-1:0] hist_q [6];
    logic [HIST_W-1:0] hist_d [6];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            hist_d[i] = hist_q[i];
            if (legal_settle && (p_face == face_t'(i + 1)) && (hist_q[i] != '1)) begin
                hist_d[i] = hist_q[i] + 1'b1;
            end
            if (clear) begin
                hist_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    always_comb begin
        hist_count = '0;
        for (int i = 0; i < 6; i++) begin
            if (hist_sel == 3'(i + 1)) begin
                hist_count = hist_q[i];
            end
        end
    end
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_die_face_reader.sv
// Directed bench for die_face_reader with STABLE_CYCLES=4; inputs change and outputs
// are sampled on the falling clock edge.
module tb_die_face_reader;

    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned HIST_W        = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [6:0]        seg_in = 7'h4F;
    logic              clear = 1'b0;
    logic [2:0]        face;
    logic              face_valid;
    logic              face_strobe;
    logic              error;
    logic [CNT_W-1:0]  roll_count;
    logic [2:0]        hist_sel = 3'd3;
    logic [HIST_W-1:0] hist_count;

    int errors = 0;
    int checks = 0;
    int strobe_total = 0;
    int snap;

    always #5 clk = ~clk;

    die_face_reader #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W),
        .HIST_W        (HIST_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .clear       (clear),
        .face        (face),
        .face_valid  (face_valid),
        .face_strobe (face_strobe),
        .error       (error),
        .roll_count  (roll_count),
        .hist_sel    (hist_sel),
        .hist_count  (hist_count)
    );

    always @(posedge clk) begin
        #1;
        if (face_strobe) strobe_total++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe must appear only in the window after the 7th rising edge.
    task automatic check_latency(input string tag);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s_edge%0d", tag, k), 32'(face_strobe), 32'(k == 7));
        end
    endtask

    initial begin
        // Reset with 0x4F already on the bus.
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_face", 32'(face), 32'd0);
        check_eq("rst_valid", 32'(face_valid), 32'd0);
        check_eq("rst_strobe", 32'(face_strobe), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_roll", 32'(roll_count), 32'd0);
        check_eq("rst_hist", 32'(hist_count), 32'd0);
        cycles(2);
        rst_n = 1'b1;

        // 1: hold 0x4F from reset release.
        check_latency("t1_lat");
        check_eq("t1_face", 32'(face), 32'd3);
        check_eq("t1_valid", 32'(face_valid), 32'd1);
        check_eq("t1_roll", 32'(roll_count), 32'd1);
        check_eq("t1_strobes", 32'(strobe_total), 32'd1);
`ifdef DIE_FACE_READER_HIST_EN
        check_eq("t1_hist3", 32'(hist_count), 32'd1);
`endif

        // 2: short 0x66 glitch, then 0x7D held.
        snap = strobe_total;
        seg_in = 7'h66;
        cycles(3);
        seg_in = 7'h7D;
        cycles(12);
        check_eq("t2_strobes", 32'(strobe_total - snap), 32'd1);
        check_eq("t2_face", 32'(face), 32'd6);
        check_eq("t2_roll", 32'(roll_count), 32'd2);

        // 3: illegal pattern, then clear.
        snap = strobe_total;
        seg_in = 7'h7F;
        cycles(10);
        check_eq("t3_strobes", 32'(strobe_total - snap), 32'd0);
        check_eq("t3_error", 32'(error), 32'd1);
        check_eq("t3_valid", 32'(face_valid), 32'd0);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check_eq("t3_clr_error", 32'(error), 32'd0);
        check_eq("t3_clr_roll", 32'(roll_count), 32'd0);
        check_eq("t3_clr_face", 32'(face), 32'd6);

        // 4: walk all faces at 2 cycles each, then hold 0x6D.
        snap = strobe_total;
        seg_in = 7'h06; cycles(2);
        seg_in = 7'h5B; cycles(2);
        seg_in = 7'h4F; cycles(2);
        seg_in = 7'h66; cycles(2);
        seg_in = 7'h6D; cycles(2);
        seg_in = 7'h7D; cycles(2);
        seg_in = 7'h6D; cycles(12);
        check_eq("t4_strobes", 32'(strobe_total - snap), 32'd1);
        check_eq("t4_face", 32'(face), 32'd5);
        check_eq("t4_roll", 32'(roll_count), 32'd1);
        check_eq("t4_error", 32'(error), 32'd0);

        // 5: 0x06, blank gap, 0x06 again.
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        snap = strobe_total;
        seg_in = 7'h06;
        cycles(10);
        seg_in = 7'h00;
        cycles(5);
        check_eq("t5_blank_valid", 32'(face_valid), 32'd0);
        cycles(1);
        check_eq("t5_blank_valid2", 32'(face_valid), 32'd0);
        check_eq("t5_blank_face", 32'(face), 32'd1);
        seg_in = 7'h06;
        cycles(10);
        check_eq("t5_strobes", 32'(strobe_total - snap), 32'd2);
        check_eq("t5_roll", 32'(roll_count), 32'd2);
        check_eq("t5_error", 32'(error), 32'd0);
        check_eq("t5_valid", 32'(face_valid), 32'd1);

        // 6: reset at run=3 while 0x5B is settling.
        seg_in = 7'h5B;
        cycles(6);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_face", 32'(face), 32'd0);
        check_eq("t6_rst_valid", 32'(face_valid), 32'd0);
        check_eq("t6_rst_roll", 32'(roll_count), 32'd0);
        check_eq("t6_rst_error", 32'(error), 32'd0);
        cycles(1);
        rst_n = 1'b1;
        check_latency("t6_lat");
        check_eq("t6_face", 32'(face), 32'd2);
        check_eq("t6_roll", 32'(roll_count), 32'd1);
        check_eq("t6_valid", 32'(face_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
